// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port DataMem.
// One transaction in flight at a time: IDLE (grant/latch) -> ACCESS (drive memory) -> RESP (return data).
module dmem_arbiter #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0Req,
  input  logic [addrWidth-1:0] m0Addr,
  input  logic [dataWidth-1:0] m0Din,
  input  logic [2:0]           m0MemOp,
  input  logic                 m0We,
  output logic                 m0Gnt,
  output logic                 m0RspValid,
  output logic [dataWidth-1:0] m0Dout,
  output logic                 m0Err,
  input  logic                 m1Req,
  input  logic [addrWidth-1:0] m1Addr,
  input  logic [dataWidth-1:0] m1Din,
  input  logic [2:0]           m1MemOp,
  input  logic                 m1We,
  output logic                 m1Gnt,
  output logic                 m1RspValid,
  output logic [dataWidth-1:0] m1Dout,
  output logic                 m1Err,
  output logic [addrWidth-1:0] memAddr,
  output logic [dataWidth-1:0] memDin,
  output logic [2:0]           memMemOp,
  output logic                 memWe,
  input  logic [dataWidth-1:0] memDout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [dataWidth-1:0] din_q, din_d;
  logic [2:0]           op_q, op_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic                 sel;
  logic [dataWidth-1:0] rsp_data;

  // Misaligned halfword/word accesses, reserved opcodes and unsigned-store opcodes all fault.
  function automatic logic access_fault(input logic [1:0] lsb, input logic [2:0] op,
                                        input logic we);
    case (op)
      3'd0:    access_fault = 1'b0;
      3'd1:    access_fault = lsb[0];
      3'd2:    access_fault = |lsb;
      3'd4:    access_fault = we;
      3'd5:    access_fault = lsb[0] | we;
      default: access_fault = 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    din_d      = din_q;
    op_d       = op_q;
    we_d       = we_q;
    err_d      = err_q;
    sel        = (m0Req & m1Req) ? ~last_q : m1Req;
    rsp_data   = '0;
    m0Gnt      = 1'b0;
    m1Gnt      = 1'b0;
    m0RspValid = 1'b0;
    m1RspValid = 1'b0;
    m0Dout     = '0;
    m1Dout     = '0;
    m0Err      = 1'b0;
    m1Err      = 1'b0;
    memAddr    = '0;
    memDin     = '0;
    memMemOp   = 3'd2;
    memWe      = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0Req | m1Req) begin
          m0Gnt   = ~sel;
          m1Gnt   = sel;
          owner_d = sel;
          last_d  = sel;
          addr_d  = sel ? m1Addr  : m0Addr;
          din_d   = sel ? m1Din   : m0Din;
          op_d    = sel ? m1MemOp : m0MemOp;
          we_d    = sel ? m1We    : m0We;
          err_d   = access_fault(addr_d[1:0], op_d, we_d);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        memAddr  = addr_q;
        memDin   = din_q;
        memMemOp = op_q;
        memWe    = we_q & ~err_q;
        state_d  = RESP;
      end
      RESP: begin
        memAddr    = addr_q;
        memDin     = din_q;
        memMemOp   = op_q;
        rsp_data   = (we_q | err_q) ? '0 : memDout;
        m0RspValid = ~owner_q;
        m1RspValid = owner_q;
        m0Dout     = owner_q ? '0 : rsp_data;
        m1Dout     = owner_q ? rsp_data : '0;
        m0Err      = ~owner_q & err_q;
        m1Err      = owner_q & err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output, so a store caught in ACCESS never reaches memory.
    if (rst) begin
      m0Gnt      = 1'b0;
      m1Gnt      = 1'b0;
      m0RspValid = 1'b0;
      m1RspValid = 1'b0;
      m0Dout     = '0;
      m1Dout     = '0;
      m0Err      = 1'b0;
      m1Err      = 1'b0;
      memAddr    = '0;
      memDin     = '0;
      memMemOp   = 3'd2;
      memWe      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      op_q    <= op_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed DataMem model plus a transaction-level reference
// that predicts grants, response timing, data and faults from the arbitration rules.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0Req, m0We, m0Gnt, m0RspValid, m0Err;
  logic [31:0] m0Addr, m0Din, m0Dout;
  logic [2:0]  m0MemOp;
  logic        m1Req, m1We, m1Gnt, m1RspValid, m1Err;
  logic [31:0] m1Addr, m1Din, m1Dout;
  logic [2:0]  m1MemOp;
  logic [31:0] memAddr, memDin, memDout;
  logic [2:0]  memMemOp;
  logic        memWe;

  always #5 clk = ~clk;

  dmem_arbiter #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk), .rst(rst),
    .m0Req(m0Req), .m0Addr(m0Addr), .m0Din(m0Din), .m0MemOp(m0MemOp), .m0We(m0We),
    .m0Gnt(m0Gnt), .m0RspValid(m0RspValid), .m0Dout(m0Dout), .m0Err(m0Err),
    .m1Req(m1Req), .m1Addr(m1Addr), .m1Din(m1Din), .m1MemOp(m1MemOp), .m1We(m1We),
    .m1Gnt(m1Gnt), .m1RspValid(m1RspValid), .m1Dout(m1Dout), .m1Err(m1Err),
    .memAddr(memAddr), .memDin(memDin), .memMemOp(memMemOp), .memWe(memWe),
    .memDout(memDout)
  );

  logic [7:0] dmem [0:4095];
  logic [7:0] rmem [0:4095];

  function automatic int sz(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int bidx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) & 32'h0000_0FFF);
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] op);
    case (op)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd4:    return {24'h0, raw[7:0]};
      3'd5:    return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic is_err(input logic [31:0] a, input logic [2:0] op, input logic we);
    if (op == 3'd3 || op >= 3'd6) return 1'b1;
    if (we && op >= 3'd4) return 1'b1;
    return (a % 32'(sz(op))) != 0;
  endfunction

  function automatic logic [31:0] dm_word(input logic [31:0] a);
    return {dmem[bidx(a, 3)], dmem[bidx(a, 2)], dmem[bidx(a, 1)], dmem[bidx(a, 0)]};
  endfunction

  function automatic logic [31:0] rm_word(input logic [31:0] a);
    return {rmem[bidx(a, 3)], rmem[bidx(a, 2)], rmem[bidx(a, 1)], rmem[bidx(a, 0)]};
  endfunction

  // DataMem: synchronous write, registered read available the cycle after the address.
  always @(posedge clk) begin
    memDout <= ext(dm_word(memAddr), memMemOp);
    if (memWe)
      for (int i = 0; i < sz(memMemOp); i++) dmem[bidx(memAddr, i)] <= memDin[8*i +: 8];
  end

  int ntot = 0, npass = 0, nfail = 0;
  int cyc;
  logic        pend [2];
  logic [31:0] paddr [2], pdin [2];
  logic [2:0]  pop [2];
  logic        pwe [2];
  logic        m0_cont;
  int          free_cyc, rsp_cyc, we_cyc, last;
  logic        rsp_own, rsp_err;
  logic [31:0] rsp_dout, st_addr, st_din;
  logic [2:0]  st_op;
  int          obs_gcyc [2], obs_rcyc [2];
  logic [31:0] obs_dout [2];
  logic        obs_err [2];
  int          nwe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [2:0] op,
                       input logic we, input logic [31:0] d);
    pend[k] = 1'b1; paddr[k] = a; pop[k] = op; pwe[k] = we; pdin[k] = d;
  endtask

  task automatic check_cycle();
    int   win;
    logic idle, e0, e1, err;
    if (rst) begin
      chk("rst_ctl", {25'h0, m0Gnt, m1Gnt, m0RspValid, m1RspValid, m0Err, m1Err, memWe}, 32'h0);
      chk("rst_dout", m0Dout | m1Dout, 32'h0);
      chk("rst_memaddr", memAddr | memDin, 32'h0);
      chk("rst_memop", {29'h0, memMemOp}, 32'd2);
      free_cyc = cyc + 1; rsp_cyc = -1; we_cyc = -1; last = 1;
      return;
    end
    idle = (cyc >= free_cyc);
    win  = -1;
    if (idle && (pend[0] || pend[1]))
      win = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
    chk("gnt0", {31'h0, m0Gnt}, {31'h0, win == 0});
    chk("gnt1", {31'h0, m1Gnt}, {31'h0, win == 1});
    chk("memWe", {31'h0, memWe}, {31'h0, cyc == we_cyc});
    if (idle) begin
      chk("idle_addr", memAddr, 32'h0);
      chk("idle_din", memDin, 32'h0);
      chk("idle_op", {29'h0, memMemOp}, 32'd2);
    end
    e0 = (cyc == rsp_cyc) && !rsp_own;
    e1 = (cyc == rsp_cyc) && rsp_own;
    chk("rsp0", {31'h0, m0RspValid}, {31'h0, e0});
    chk("rsp1", {31'h0, m1RspValid}, {31'h0, e1});
    chk("dout0", m0Dout, e0 ? rsp_dout : 32'h0);
    chk("dout1", m1Dout, e1 ? rsp_dout : 32'h0);
    chk("err0", {31'h0, m0Err}, {31'h0, e0 && rsp_err});
    chk("err1", {31'h0, m1Err}, {31'h0, e1 && rsp_err});
    if (m0RspValid) begin obs_rcyc[0] = cyc; obs_dout[0] = m0Dout; obs_err[0] = m0Err; end
    if (m1RspValid) begin obs_rcyc[1] = cyc; obs_dout[1] = m1Dout; obs_err[1] = m1Err; end
    if (m0Gnt) obs_gcyc[0] = cyc;
    if (m1Gnt) obs_gcyc[1] = cyc;
    if (memWe === 1'b1) nwe++;
    if (cyc == we_cyc)
      for (int i = 0; i < sz(st_op); i++) rmem[bidx(st_addr, i)] = st_din[8*i +: 8];
    if (win >= 0) begin
      err      = is_err(paddr[win], pop[win], pwe[win]);
      rsp_err  = err;
      rsp_own  = (win == 1);
      rsp_cyc  = cyc + 2;
      free_cyc = cyc + 3;
      rsp_dout = (err || pwe[win]) ? 32'h0 : ext(rm_word(paddr[win]), pop[win]);
      we_cyc   = (!err && pwe[win]) ? cyc + 1 : -1;
      st_addr  = paddr[win]; st_op = pop[win]; st_din = pdin[win];
      last     = win;
      if (!(win == 0 && m0_cont)) pend[win] = 1'b0;
    end
  endtask

  task automatic cycle();
    m0Req = pend[0]; m0Addr = paddr[0]; m0Din = pdin[0]; m0MemOp = pop[0]; m0We = pwe[0];
    m1Req = pend[1]; m1Addr = paddr[1]; m1Din = pdin[1]; m1MemOp = pop[1]; m1We = pwe[1];
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend[0] || pend[1] || cyc < free_cyc) && n < 60) begin
      cycle();
      n++;
    end
    chk("drain_timeout", {31'h0, n < 60}, 32'h1);
  endtask

  task automatic clr_obs();
    for (int k = 0; k < 2; k++) begin
      obs_gcyc[k] = -1; obs_rcyc[k] = -1; obs_dout[k] = 32'hX; obs_err[k] = 1'bX;
    end
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 4096; i++) begin dmem[i] = 8'h0; rmem[i] = 8'h0; end
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; paddr[k] = '0; pdin[k] = '0; pop[k] = 3'd2; pwe[k] = 1'b0;
    end
    m0_cont = 1'b0; cyc = 0; free_cyc = 0; rsp_cyc = -1; we_cyc = -1; last = 1;
    rsp_own = 1'b0; rsp_err = 1'b0; rsp_dout = '0; st_addr = '0; st_din = '0; st_op = '0;
    nwe = 0;
    clr_obs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Contention at reset exit: m0 first, m1 three cycles later.
    rst = 1'b0;
    issue(0, 32'h100, 3'd2, 1'b0, 32'h0);
    issue(1, 32'h200, 3'd2, 1'b0, 32'h0);
    t0 = cyc;
    drain();
    chk("exit_g0", obs_gcyc[0] - t0, 32'd0);
    chk("exit_r0", obs_rcyc[0] - t0, 32'd2);
    chk("exit_g1", obs_gcyc[1] - t0, 32'd3);
    chk("exit_r1", obs_rcyc[1] - t0, 32'd5);

    // Store from m1, load back from m0.
    clr_obs(); nwe = 0;
    issue(1, 32'h40, 3'd2, 1'b1, 32'hDEAD_BEEF);
    drain();
    issue(0, 32'h40, 3'd2, 1'b0, 32'h0);
    drain();
    chk("sw_lw_dout", obs_dout[0], 32'hDEAD_BEEF);
    chk("sw_lw_we_cnt", nwe, 32'd1);

    // Misaligned accesses fault and never write.
    clr_obs(); nwe = 0;
    issue(0, 32'h41, 3'd1, 1'b0, 32'h0);
    drain();
    chk("lh_mis_err", {31'h0, obs_err[0]}, 32'h1);
    chk("lh_mis_dout", obs_dout[0], 32'h0);
    clr_obs();
    issue(0, 32'h42, 3'd2, 1'b1, 32'h1234_5678);
    drain();
    chk("sw_mis_err", {31'h0, obs_err[0]}, 32'h1);
    chk("sw_mis_dout", obs_dout[0], 32'h0);
    chk("mis_we_cnt", nwe, 32'd0);

    // Byte store, then unsigned and signed byte loads.
    issue(0, 32'h43, 3'd0, 1'b1, 32'h0000_00AA);
    drain();
    clr_obs();
    issue(0, 32'h43, 3'd4, 1'b0, 32'h0);
    drain();
    chk("lbu_dout", obs_dout[0], 32'h0000_00AA);
    clr_obs();
    issue(0, 32'h43, 3'd0, 1'b0, 32'h0);
    drain();
    chk("lb_dout", obs_dout[0], 32'hFFFF_FFAA);

    // Reset during the ACCESS cycle of an m0 store.
    clr_obs(); nwe = 0;
    issue(0, 32'h80, 3'd2, 1'b1, 32'h5555_AAAA);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    chk("rst_no_rsp0", obs_rcyc[0], 32'hFFFF_FFFF);
    chk("rst_no_we", nwe, 32'd0);
    issue(0, 32'h80, 3'd2, 1'b0, 32'h0);
    issue(1, 32'h84, 3'd2, 1'b0, 32'h0);
    t0 = cyc;
    drain();
    chk("rst_next_g0", obs_gcyc[0] - t0, 32'd0);
    chk("rst_store_dropped", obs_dout[0], 32'h0);

    // m0 requests continuously; m1 must still get the next slot.
    clr_obs();
    m0_cont = 1'b1;
    issue(0, 32'h10, 3'd2, 1'b0, 32'h0);
    t0 = cyc;
    cycle();
    issue(1, 32'h20, 3'd2, 1'b1, 32'h0BAD_F00D);
    repeat (8) cycle();
    chk("starve_g1", obs_gcyc[1] - t0, 32'd3);
    m0_cont = 1'b0;
    drain();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && $urandom_range(0, 3) == 0)
          issue(k, 32'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter addrWidth, default 32, the address width of both masters and the memory port.
REQ-002 SHALL have parameter dataWidth, default 32, the data width of both masters and the memory port.
REQ-003 SHALL have port clk  input  1  single clock; it also drives the DataMem clkRd and clkWr.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports mNReq  input  1  request from master N (N = 0, 1), held until granted.
REQ-006 SHALL have ports mNAddr  input  addrWidth  byte address from master N.
REQ-007 SHALL have ports mNDin  input  dataWidth  store data from master N.
REQ-008 SHALL have ports mNMemOp  input  3  access type: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-009 SHALL have ports mNWe  input  1  1 = store, 0 = load.
REQ-010 SHALL have ports mNGnt  output  1  request accepted this cycle.
REQ-011 SHALL have ports mNRspValid  output  1  response pulse to master N.
REQ-012 SHALL have ports mNDout  output  dataWidth  load data, valid with mNRspValid.
REQ-013 SHALL have ports mNErr  output  1  access fault, valid with mNRspValid.
REQ-014 SHALL have port memAddr  output  addrWidth  address to DataMem.
REQ-015 SHALL have port memDin  output  dataWidth  store data to DataMem.
REQ-016 SHALL have port memMemOp  output  3  access type to DataMem.
REQ-017 SHALL have port memWe  output  1  write enable to DataMem.
REQ-018 SHALL have port memDout  input  dataWidth  DataMem read data, available in the cycle after the address is driven.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP, with at most one transaction outstanding.
REQ-020 SHALL, in IDLE with at least one mNReq high, assert exactly one mNGnt combinationally in that cycle and latch addr/din/memOp/we/owner at the clock edge; next state ACCESS.
REQ-021 SHALL arbitrate round-robin: when both masters request, grant the master not granted last.
REQ-022 SHALL grant a lone requester regardless of the last-owner register, which then records the granted master.
REQ-023 SHALL never assert mNGnt outside IDLE.
REQ-024 SHALL, in ACCESS, drive memAddr/memMemOp/memDin from the latched request and set memWe = latched we for exactly this one cycle; next state RESP.
REQ-025 SHALL, in RESP, keep memAddr/memMemOp driven and memWe=0, and pulse the owner's mNRspValid for one cycle; next state IDLE.
REQ-026 SHALL set mNDout = memDout in RESP for loads and mNDout = 0 for stores.
REQ-027 SHALL complete each legal transaction with RspValid 2 cycles after the grant cycle; back-to-back grants SHALL be 3 cycles apart.
REQ-028 SHALL treat as misaligned: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
REQ-029 SHALL treat as illegal: memOp 3, 6 or 7, and stores with memOp 4 or 5.
REQ-030 SHALL, for a misaligned or illegal request, still grant it and go IDLE→ACCESS→RESP, hold memWe=0 in ACCESS, and return mNErr=1 with mNDout=0.
REQ-031 SHALL hold all mN outputs of the non-owner, and mNErr outside RESP, at 0.
REQ-032 SHALL drive memWe=0, memAddr=0, memDin=0 and memMemOp=2 when in IDLE.

Reset
REQ-033 SHALL, when rst is sampled high, enter IDLE, set last-owner = 1 (so master 0 wins the first contention) and clear all latched request registers.
REQ-034 SHALL, while rst is high, hold all outputs at 0 except memMemOp=2.
REQ-035 SHALL, on reset during ACCESS or RESP, drop the transaction with no RspValid; a write whose ACCESS coincides with the reset edge SHALL NOT occur (memWe is gated by rst).

Verification
REQ-036 SHALL cover: both masters request LW at reset exit (m0 addr 0x100, m1 addr 0x200) -> m0Gnt at cycle 0, m0RspValid at cycle 2, m1Gnt at cycle 3, m1RspValid at cycle 5.
REQ-037 SHALL cover: m1 issues SW 0xDEADBEEF to 0x40, then m0 issues LW from 0x40 -> m0Dout=0xDEADBEEF, memWe high for exactly one cycle.
REQ-038 SHALL cover: m0 issues LH to 0x41 and SW to 0x42 -> each response has m0Err=1 and m0Dout=0, with memWe never asserted.
REQ-039 SHALL cover: m0 issues SB 0xAA to 0x43, then LBU from 0x43 -> m0Dout=0x000000AA; LB from 0x43 -> 0xFFFFFFAA.
REQ-040 SHALL cover: rst asserted in the ACCESS cycle of a store -> memWe=0, no RspValid, next grant goes to m0 under contention.
REQ-041 SHALL cover: m0 requests continuously while m1 requests once -> m1 is granted at the first IDLE after m0's grant (no starvation).
